vram_fill_ctrl: RTL and testbench

Hardware fill/clear engine and port arbiter for the CPU-side port of the five 4K×1 VRAM blocks (0x1000–0x5FFF). It shares that single port between CPU loads/stores and a block-fill sequencer that writes a constant pixel value over an address range. The CPU always wins a contested cycle; the sequencer only advances in cycles the CPU leaves free. It sits between the DLX data-memory bus and the VRAM port-A pins.

---
 rtl/vram_fill_ctrl_pkg.sv | 13 +
 rtl/vram_fill_ctrl_if.sv | 30 +++
 rtl/vram_bank_decode.sv | 11 +
 rtl/vram_fill_ctrl.sv | 75 +++++++
 tb/tb_vram_fill_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/vram_fill_ctrl_pkg.sv
// vram_fill_ctrl_pkg: shared constants, FSM states and bank decode for the VRAM fill engine.
package vram_fill_ctrl_pkg;
  localparam int ADDR_W = 15;
  localparam int NBANKS = 5;
  localparam logic [ADDR_W-1:0] VRAM_BASE = 15'h1000;
  localparam logic [ADDR_W-1:0] VRAM_TOP  = 15'h5FFF;
  typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;
  // Block 0 and blocks 6/7 are not VRAM, so they never get an enable.
  function automatic logic [NBANKS-1:0] bank_en(input logic [2:0] idx);
    bank_en = '0;
    if (idx >= 3'd1 && idx <= 3'(NBANKS)) bank_en[idx - 3'd1] = 1'b1;
  endfunction
endpackage

// File: rtl/vram_fill_ctrl_if.sv
// vram_fill_ctrl_if: CPU port, fill command and VRAM port-A signals of the fill engine.
interface vram_fill_ctrl_if;
  import vram_fill_ctrl_pkg::*;
  logic              i_cpu_req;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic              i_cpu_wdata;
  logic              i_start;
  logic [ADDR_W-1:0] i_fill_base;
  logic [ADDR_W-1:0] i_fill_len;
  logic              i_fill_val;
  logic              i_abort;
  logic [11:0]       o_vram_addr;
  logic [NBANKS-1:0] o_vram_en;
  logic              o_vram_we;
  logic              o_vram_din;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_start, i_fill_base, i_fill_len,
           i_fill_val, i_abort,
    output o_vram_addr, o_vram_en, o_vram_we, o_vram_din, o_busy, o_done, o_err
  );
  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_start, i_fill_base, i_fill_len,
           i_fill_val, i_abort,
    input  o_vram_addr, o_vram_en, o_vram_we, o_vram_din, o_busy, o_done, o_err
  );
endinterface

// File: rtl/vram_bank_decode.sv
// vram_bank_decode: splits a data address into a one-hot VRAM block enable and a local bit address.
module vram_bank_decode
  import vram_fill_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  output logic [NBANKS-1:0] o_en,
  output logic [11:0]       o_addr
);
  assign o_en   = bank_en(i_addr[14:12]);
  assign o_addr = i_addr[11:0];
endmodule

// File: rtl/vram_fill_ctrl.sv
// vram_fill_ctrl: block-fill sequencer sharing the VRAM CPU port; the CPU always wins a contested cycle.
module vram_fill_ctrl
  import vram_fill_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  vram_fill_ctrl_if.slave bus
);
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0] r_rem, w_rem_nxt;
  logic              r_val, w_val_nxt;
  logic              r_err, w_err_nxt;
  logic              w_wr, w_bad, w_fill;
  logic [NBANKS-1:0] w_cpu_en, w_eng_en;
  logic [11:0]       w_cpu_addr, w_eng_addr;

  vram_bank_decode u_cpu_dec (.i_addr(bus.i_cpu_addr), .o_en(w_cpu_en), .o_addr(w_cpu_addr));
  vram_bank_decode u_eng_dec (.i_addr(r_ptr), .o_en(w_eng_en), .o_addr(w_eng_addr));

  assign w_fill = r_state == FILL;
  assign w_wr   = w_fill && !bus.i_cpu_req;
  assign w_bad  = bus.i_fill_base < VRAM_BASE || bus.i_fill_base > VRAM_TOP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_val   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rem   <= w_rem_nxt;
      r_val   <= w_val_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_val_nxt   = r_val;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: if (bus.i_start) begin
        w_ptr_nxt   = bus.i_fill_base;
        w_rem_nxt   = bus.i_fill_len;
        w_val_nxt   = bus.i_fill_val;
        w_err_nxt   = w_bad;
        w_state_nxt = (w_bad || bus.i_fill_len == '0) ? FINISH : FILL;
      end
      FILL: begin
        if (w_wr) begin
          w_ptr_nxt = r_ptr + 15'd1;
          w_rem_nxt = r_rem - 15'd1;
        end
        // Abort beats both normal completion and the truncation error.
        if (bus.i_abort || (w_wr && (r_rem == 15'd1 || r_ptr == VRAM_TOP))) w_state_nxt = FINISH;
        if (!bus.i_abort && w_wr && r_rem != 15'd1 && r_ptr == VRAM_TOP) w_err_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.o_vram_addr = bus.i_cpu_req ? w_cpu_addr : (w_fill ? w_eng_addr : '0);
  assign bus.o_vram_en   = bus.i_cpu_req ? w_cpu_en : (w_fill ? w_eng_en : '0);
  assign bus.o_vram_we   = bus.i_cpu_req ? bus.i_cpu_we : w_fill;
  assign bus.o_vram_din  = bus.i_cpu_req ? bus.i_cpu_wdata : (w_fill && r_val);
  assign bus.o_busy      = r_state != IDLE;
  assign bus.o_done      = r_state == FINISH;
  assign bus.o_err       = r_err;
endmodule

// File: tb/tb_vram_fill_ctrl.sv
// tb_vram_fill_ctrl: directed and randomized fills checked against a per-fill write-list model.
module tb_vram_fill_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  vram_fill_ctrl_if bus ();
  vram_fill_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_en(input int a);
    int idx;
    idx = a / 4096;
    return (idx >= 1 && idx <= 5) ? 5'(1 << (idx - 1)) : 5'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic port_chk(input string tag, input logic [4:0] en, input int addr,
                          input logic we, input logic din);
    chk({tag, ".en"}, 32'(bus.o_vram_en), 32'(en));
    chk({tag, ".addr"}, 32'(bus.o_vram_addr), 32'(addr));
    chk({tag, ".we"}, 32'(bus.o_vram_we), 32'(we));
    chk({tag, ".din"}, 32'(bus.o_vram_din), 32'(din));
  endtask

  task automatic idle_inputs();
    bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = 0;
    bus.i_start = 0; bus.i_fill_base = '0; bus.i_fill_len = '0; bus.i_fill_val = 0;
    bus.i_abort = 0;
  endtask

  // Model: a fill writes min(len, room-to-top) pixels from base, one per CPU-free cycle,
  // then pulses done once; abort cuts the list short after the write it coincides with.
  task automatic run_fill(input int base, input int len, input bit val, input int fixed_stall,
                          input bit rnd, input int abort_at, input bit poke);
    int room, nw, written, cyc;
    bit bad, exp_err, fin, stall;
    bad = base < 'h1000 || base > 'h5FFF;
    room = bad ? 0 : 'h6000 - base;
    nw = len < room ? len : room;
    exp_err = bad || (len > room && !(abort_at > 0 && abort_at <= room));
    if (abort_at > 0 && abort_at < nw) nw = abort_at;
    written = 0; cyc = 0; fin = 0;
    @(posedge clk); #1;
    idle_inputs();
    bus.i_start = 1; bus.i_fill_base = 15'(base); bus.i_fill_len = 15'(len); bus.i_fill_val = val;
    #1 chk("pre.busy", 32'(bus.o_busy), 0);
    while (!fin && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      bus.i_start = poke && ($urandom % 3 == 0);
      bus.i_fill_base = 15'($urandom); bus.i_fill_len = 15'($urandom); bus.i_fill_val = 1'($urandom);
      bus.i_abort = 0;
      stall = (cyc == fixed_stall) || (rnd && $urandom % 3 == 0);
      bus.i_cpu_req = stall;
      bus.i_cpu_addr = (cyc == fixed_stall) ? 15'h2010 : 15'($urandom);
      bus.i_cpu_we = (cyc == fixed_stall) ? 1'b1 : 1'($urandom);
      bus.i_cpu_wdata = (cyc == fixed_stall) ? 1'b0 : 1'($urandom);
      if (written < nw) begin
        if (!stall) begin
          written++;
          if (abort_at > 0 && written == abort_at) bus.i_abort = 1;
        end
        #1;
        chk("fill.busy", 32'(bus.o_busy), 1);
        chk("fill.done", 32'(bus.o_done), 0);
        if (stall)
          port_chk("cpu", exp_en(int'(bus.i_cpu_addr)), int'(bus.i_cpu_addr) % 4096,
                   bus.i_cpu_we, bus.i_cpu_wdata);
        else
          port_chk("wr", exp_en(base + written - 1), (base + written - 1) % 4096, 1'b1, val);
      end else begin
        #1;
        chk("fin.done", 32'(bus.o_done), 1);
        chk("fin.busy", 32'(bus.o_busy), 1);
        chk("fin.err", 32'(bus.o_err), 32'(exp_err));
        if (stall)
          port_chk("fin.cpu", exp_en(int'(bus.i_cpu_addr)), int'(bus.i_cpu_addr) % 4096,
                   bus.i_cpu_we, bus.i_cpu_wdata);
        else
          port_chk("fin.idle", 5'd0, 0, 1'b0, 1'b0);
        fin = 1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("post.busy", 32'(bus.o_busy), 0);
    chk("post.done", 32'(bus.o_done), 0);
    chk("post.err", 32'(bus.o_err), 32'(exp_err));
  endtask

  initial begin
    int b, l, mode, ab;
    idle_inputs();
    #1;
    chk("rst.busy", 32'(bus.o_busy), 0);
    chk("rst.done", 32'(bus.o_done), 0);
    chk("rst.err", 32'(bus.o_err), 0);
    port_chk("rst", 5'd0, 0, 1'b0, 1'b0);
    #22 reset = 0;

    run_fill('h1000, 4, 1, -1, 0, 0, 0);
    run_fill('h1000, 4, 1, 2, 0, 0, 0);
    run_fill('h5FFE, 5, 1, -1, 0, 0, 0);
    run_fill('h0800, 3, 1, -1, 0, 0, 0);
    run_fill('h1000, 0, 1, -1, 0, 0, 0);
    run_fill('h6000, 2, 0, -1, 0, 0, 0);
    run_fill('h3000, 10, 1, -1, 0, 3, 1);
    run_fill('h5FFF, 1, 0, -1, 0, 0, 0);

    @(posedge clk); #1;
    bus.i_start = 1; bus.i_fill_base = 15'h4000; bus.i_fill_len = 15'd20; bus.i_fill_val = 1;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("arst.busy", 32'(bus.o_busy), 0);
    chk("arst.done", 32'(bus.o_done), 0);
    chk("arst.err", 32'(bus.o_err), 0);
    port_chk("arst", 5'd0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("arst.nodone", 32'(bus.o_done), 0);
    #2 reset = 0;
    run_fill('h2100, 6, 1, -1, 1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom % 4);
      ab = 0;
      case (mode)
        0: begin b = 'h1000 + int'($urandom % 'h5000); l = int'($urandom % 41); end
        1: begin b = 'h5FFF - int'($urandom % 8); l = 1 + int'($urandom % 20); end
        2: begin
          b = ($urandom % 2 == 0) ? int'($urandom % 'h1000) : 'h6000 + int'($urandom % 'h2000);
          l = int'($urandom % 16);
        end
        default: begin
          b = 'h1000 + int'($urandom % 'h4000); l = 2 + int'($urandom % 15);
          ab = 1 + int'($urandom % l);
        end
      endcase
      run_fill(b, l, 1'($urandom), -1, 1, ab, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
